// File: rtl/mem_responder_pkg.sv
// Shared types and lane helpers for the memory responder and its SRAM.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        MS_B = 2'd0,
        MS_H = 2'd1,
        MS_W = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAITST = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } rsp_state_t;

    // Halves must sit on even bytes, words on word boundaries; size 2'b11 is never legal.
    function automatic logic misaligned(input logic [1:0] off, input mem_size_t size);
        case (size)
            MS_B:    misaligned = 1'b0;
            MS_H:    misaligned = off[0];
            MS_W:    misaligned = (off != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] off, input mem_size_t size);
        case (size)
            MS_B:    byte_en = 4'b0001 << off;
            MS_H:    byte_en = 4'b0011 << off;
            MS_W:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    // Right-aligned store data replicated so every lane carries it; byte enables pick the lane.
    function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input mem_size_t size);
        case (size)
            MS_B:    store_lanes = {4{wdata[7:0]}};
            MS_H:    store_lanes = {2{wdata[15:0]}};
            default: store_lanes = wdata;
        endcase
    endfunction

    // Pull the addressed byte/half out of the SRAM word and sign- or zero-extend it.
    function automatic logic [31:0] lane_extract(input logic [31:0] rdata, input logic [1:0] off,
                                                 input mem_size_t size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            MS_B:    lane_extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
            MS_H:    lane_extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: lane_extract = rdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core request/response and SRAM port bundle for the memory responder.
// Latency: n/a (wires only).
// Backpressure: core holds req_rden/req_wren until the done pulse.
interface mem_responder_if #(
    parameter int AW = 12
);
    import mem_responder_pkg::*;

    logic            req_rden;
    logic            req_wren;
    logic [31:0]     req_addr;
    mem_size_t       req_size;
    logic            req_unsigned;
    logic [31:0]     req_wdata;
    logic            done;
    logic [31:0]     rdata;
    logic            err;

    logic            sram_en;
    logic            sram_we;
    logic [AW-1:0]   sram_addr;
    logic [3:0]      sram_be;
    logic [31:0]     sram_wdata;
    logic [31:0]     sram_rdata;

    modport master (
        output req_rden, req_wren, req_addr, req_size, req_unsigned, req_wdata,
        input  done, rdata, err
    );

    modport slave (
        input  req_rden, req_wren, req_addr, req_size, req_unsigned, req_wdata, sram_rdata,
        output done, rdata, err, sram_en, sram_we, sram_addr, sram_be, sram_wdata
    );

    modport mem (
        input  sram_en, sram_we, sram_addr, sram_be, sram_wdata,
        output sram_rdata
    );

endinterface

// File: rtl/sram_1rw.sv
// 2^AW x 32 single-port SRAM, byte-enabled writes, synchronous read.
// Latency: read data appears the cycle after sram_en with sram_we=0.
// Backpressure: none; accepts one access per enabled cycle.
module sram_1rw #(
    parameter int AW = 12
) (
    input  logic         clk,
    mem_responder_if.mem bus
);
    logic [31:0] mem_q [0:(1<<AW)-1];
    logic [31:0] rdata_q;

    // Byte-lane write
    always_ff @(posedge clk) begin
        if (bus.sram_en && bus.sram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.sram_be[i]) begin
                    mem_q[bus.sram_addr][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read; output holds until the next read
    always_ff @(posedge clk) begin
        if (bus.sram_en && !bus.sram_we) begin
            rdata_q <= mem_q[bus.sram_addr];
        end
    end

    assign bus.sram_rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Turns held core load/store requests into one SRAM access and a done pulse; MEMRESP_WAIT_EN adds WAIT wait states.
// Latency: done WAIT+2 cycles after the request is seen in IDLE (2 cycles when MEMRESP_WAIT_EN is undefined).
// Backpressure: one request in flight; the core holds its request level until done, next sample is the cycle after done.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int AW   = 12,
    parameter int WAIT = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    if (WAIT < 0 || WAIT > 15 || AW < 1 || AW > 29) begin : g_param_chk
        $error("mem_responder: WAIT must be 0..15 and AW 1..29");
    end

    rsp_state_t    state_q, state_d;
    logic [AW+1:0] addr_q;
    mem_size_t     size_q;
    logic          uns_q;
    logic          wr_q;
    logic          err_q;
    logic [31:0]   wdata_q;

    logic          req_any;
    logic          req_bad;
    logic          done_c;
    logic          en_c;
    logic          we_c;

`ifdef MEMRESP_WAIT_EN
    localparam logic [3:0] WAIT_LD = 4'(WAIT);
    logic [3:0] cnt_q, cnt_d;
`endif

    assign req_any = bus.req_rden | bus.req_wren;
    // Faulting requests still walk the full state sequence so timing never depends on the address.
    assign req_bad = misaligned(bus.req_addr[1:0], bus.req_size)
                   | (|bus.req_addr[31:AW+2])
                   | (bus.req_rden & bus.req_wren);

    // Capture the whole request when IDLE accepts it
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            size_q  <= MS_B;
            uns_q   <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else if (state_q == IDLE && req_any) begin
            addr_q  <= bus.req_addr[AW+1:0];
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            wr_q    <= bus.req_wren;
            err_q   <= req_bad;
            wdata_q <= bus.req_wdata;
        end
    end

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
`ifdef MEMRESP_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef MEMRESP_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next state and per-state strobes; strobes are masked during reset so an aborted write never lands
    always_comb begin
        state_d = state_q;
`ifdef MEMRESP_WAIT_EN
        cnt_d   = cnt_q;
`endif
        done_c  = 1'b0;
        en_c    = 1'b0;
        we_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
`ifdef MEMRESP_WAIT_EN
                    if (WAIT_LD != 4'd0) begin
                        state_d = WAITST;
                        cnt_d   = WAIT_LD;
                    end else begin
                        state_d = ACCESS;
                    end
`else
                    state_d = ACCESS;
`endif
                end
            end
            WAITST: begin
`ifdef MEMRESP_WAIT_EN
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACCESS;
                end
`else
                state_d = IDLE;
`endif
            end
            ACCESS: begin
                en_c    = ~err_q;
                we_c    = ~err_q & wr_q;
                state_d = RESP;
            end
            RESP: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            done_c = 1'b0;
            en_c   = 1'b0;
            we_c   = 1'b0;
        end
    end

    assign bus.done       = done_c;
    assign bus.err        = done_c & err_q;
    assign bus.rdata      = (done_c && !err_q && !wr_q)
                          ? lane_extract(bus.sram_rdata, addr_q[1:0], size_q, uns_q) : '0;
    assign bus.sram_en    = en_c;
    assign bus.sram_we    = we_c;
    assign bus.sram_addr  = addr_q[AW+1:2];
    assign bus.sram_be    = byte_en(addr_q[1:0], size_q);
    assign bus.sram_wdata = store_lanes(wdata_q, size_q);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with sram_1rw behind it and a byte-level memory model.
// Latency: expects done LAT cycles after acceptance (WAIT+2 with MEMRESP_WAIT_EN, else 2).
// Backpressure: requests held until their done cycle, next request driven the cycle after.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int AW = 12;
`ifdef MEMRESP_WAIT_EN
    localparam int WAIT        = 2;
    localparam int LAT         = WAIT + 2;
    localparam int LAT_LIT     = 4;
    localparam int SPACING_LIT = 5;
`else
    localparam int WAIT        = 7;
    localparam int LAT         = 2;
    localparam int LAT_LIT     = 2;
    localparam int SPACING_LIT = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if #(.AW(AW)) bus ();
    mem_responder #(.AW(AW), .WAIT(WAIT)) dut (.clk(clk), .rst(rst), .bus(bus));
    sram_1rw #(.AW(AW)) u_sram (.clk(clk), .bus(bus));

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        bit          chk_rdata;
    } rsp_t;

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   wdata;
    } acc_t;

    rsp_t        rsp_q[$];
    acc_t        acc_q[$];
    logic [7:0]  mm [logic [31:0]];

    int          cyc = 0;
    int          idle_from = 0;
    int          total = 0;
    int          bad = 0;
    bit          chk_on = 1'b0;
    int          done_cnt = 0;
    int          en_cnt = 0;
    int          we_cnt = 0;
    int          last_done_cyc = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [3:0]  last_be = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin : cmp
            bit edone;
            bit een;
            edone = (rsp_q.size() > 0) && (rsp_q[0].cyc == cyc);
            een   = (acc_q.size() > 0) && (acc_q[0].cyc == cyc);
            check("done", 32'(bus.done), 32'(edone));
            if (bus.done) begin
                done_cnt++;
                last_done_cyc = cyc;
                last_rdata    = bus.rdata;
                last_err      = bus.err;
            end
            if (edone) begin
                check("err", 32'(bus.err), 32'(rsp_q[0].err));
                if (rsp_q[0].chk_rdata) check("rdata", bus.rdata, rsp_q[0].rdata);
                void'(rsp_q.pop_front());
            end
            check("sram_en", 32'(bus.sram_en), 32'(een));
            if (bus.sram_en) en_cnt++;
            if (bus.sram_en && bus.sram_we) begin
                we_cnt++;
                last_be = bus.sram_be;
            end
            if (een) begin
                check("sram_we", 32'(bus.sram_we), 32'(acc_q[0].we));
                check("sram_addr", 32'(bus.sram_addr), 32'(acc_q[0].addr));
                if (acc_q[0].we) begin
                    check("sram_be", 32'(bus.sram_be), 32'(acc_q[0].be));
                    check("sram_wdata", bus.sram_wdata, acc_q[0].wdata);
                end
                void'(acc_q.pop_front());
            end else begin
                check("sram_we_idle", 32'(bus.sram_we), 32'd0);
            end
        end
    end

    // Model the request, drive it, and hold it through its expected done cycle.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input mem_size_t sz,
                       input logic uns, input logic [31:0] wd, output int acc_cyc);
        int          nb;
        int          n;
        int          d;
        bit          e;
        logic [31:0] v;
        acc_t        ac;
        rsp_t        rs;
        nb = (sz == MS_B) ? 1 : (sz == MS_H) ? 2 : 4;
        e  = ((a % nb) != 0) || (longint'(a) >= (longint'(4) << AW)) || (rd && wr);
        n  = (cyc > idle_from) ? cyc : idle_from;
        d  = n + LAT;
        idle_from = d + 1;
        v = '0;
        if (!e && rd) begin
            for (int i = 0; i < nb; i++)
                v = v | (32'(mm.exists(a + i) ? mm[a + i] : 8'h00) << (8 * i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        end
        if (!e && wr) begin
            for (int i = 0; i < nb; i++) mm[a + i] = wd[8*i +: 8];
        end
        rs.cyc = d; rs.rdata = v; rs.err = e; rs.chk_rdata = rd || e;
        rsp_q.push_back(rs);
        if (!e) begin
            ac.cyc  = d - 1;
            ac.we   = wr;
            ac.addr = AW'(a >> 2);
            ac.be   = '0;
            for (int i = 0; i < nb; i++) ac.be[(a % 4) + i] = 1'b1;
            ac.wdata = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
            acc_q.push_back(ac);
        end
        bus.req_rden     = rd;
        bus.req_wren     = wr;
        bus.req_addr     = a;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_wdata    = wd;
        acc_cyc = n;
        do begin
            @(posedge clk); #1;
        end while (cyc <= d);
    endtask

    task automatic idle(input int k);
        bus.req_rden = 1'b0;
        bus.req_wren = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int d0;
        int e0;
        int d1;
        rst = 1'b1;
        bus.req_rden = 1'b0; bus.req_wren = 1'b0; bus.req_addr = '0;
        bus.req_size = MS_W; bus.req_unsigned = 1'b0; bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_sram_en", 32'(bus.sram_en), 32'd0);
        check("rst_sram_we", 32'(bus.sram_we), 32'd0);
        rst = 1'b0;
        idle_from = cyc;
        chk_on = 1'b1;
        idle(1);

        // Word write then read back, with latency pinned
        req(1'b0, 1'b1, 32'h10, MS_W, 1'b0, 32'hDEADBEEF, n);
        check("lat_wr", 32'(last_done_cyc - n), 32'(LAT_LIT));
        idle(1);
        req(1'b1, 1'b0, 32'h10, MS_W, 1'b0, 32'h0, n);
        check("lat_rd", 32'(last_done_cyc - n), 32'(LAT_LIT));
        check("rd_w_lit", last_rdata, 32'hDEADBEEF);
        check("rd_w_err", 32'(last_err), 32'd0);
        idle(1);
        req(1'b1, 1'b0, 32'h12, MS_B, 1'b0, 32'h0, n);
        check("rd_b2_lit", last_rdata, 32'hFFFFFFAD);

        // Byte store into the top lane, signed and unsigned reloads
        idle(2);
        req(1'b0, 1'b1, 32'h13, MS_B, 1'b0, 32'h00000080, n);
        check("be_b3_lit", 32'(last_be), 32'b1000);
        idle(1);
        req(1'b1, 1'b0, 32'h13, MS_B, 1'b0, 32'h0, n);
        check("rd_bs_lit", last_rdata, 32'hFFFFFF80);
        idle(1);
        req(1'b1, 1'b0, 32'h13, MS_B, 1'b1, 32'h0, n);
        check("rd_bu_lit", last_rdata, 32'h00000080);
        idle(1);
        req(1'b1, 1'b0, 32'h10, MS_W, 1'b0, 32'h0, n);
        check("rd_merge_lit", last_rdata, 32'h80ADBEEF);

        // Faults: misaligned half, out-of-range word, rden+wren together
        idle(1);
        e0 = en_cnt;
        req(1'b1, 1'b0, 32'h11, MS_H, 1'b0, 32'h0, n);
        check("mis_h_err", 32'(last_err), 32'd1);
        check("mis_h_rdata", last_rdata, 32'd0);
        check("mis_h_lat", 32'(last_done_cyc - n), 32'(LAT_LIT));
        check("mis_h_no_en", 32'(en_cnt), 32'(e0));
        idle(1);
        req(1'b1, 1'b0, 32'h4000, MS_W, 1'b0, 32'h0, n);
        check("oor_err", 32'(last_err), 32'd1);
        idle(1);
        req(1'b1, 1'b1, 32'h10, MS_W, 1'b0, 32'h0, n);
        check("rdwr_err", 32'(last_err), 32'd1);

        // Reset in the cycle after acceptance aborts a word write
        idle(1);
        req(1'b0, 1'b1, 32'h20, MS_W, 1'b0, 32'h12345678, n);
        idle(1);
        d0 = done_cnt;
        e0 = we_cnt;
        bus.req_wren = 1'b1; bus.req_addr = 32'h20; bus.req_size = MS_W; bus.req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req_wren = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_from = cyc;
        idle(LAT + 2);
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        check("abort_no_write", 32'(we_cnt), 32'(e0));
        req(1'b1, 1'b0, 32'h20, MS_W, 1'b0, 32'h0, n);
        check("abort_prior_lit", last_rdata, 32'h12345678);

        // Back-to-back: half store then two held half loads of the same location
        idle(1);
        req(1'b0, 1'b1, 32'h22, MS_H, 1'b0, 32'h0000BEEF, n);
        d1 = last_done_cyc;
        req(1'b1, 1'b0, 32'h22, MS_H, 1'b1, 32'h0, n);
        check("b2b_accept", 32'(n), 32'(d1 + 1));
        check("b2b_spacing1", 32'(last_done_cyc - d1), 32'(SPACING_LIT));
        check("b2b_hu_lit", last_rdata, 32'h0000BEEF);
        d1 = last_done_cyc;
        req(1'b1, 1'b0, 32'h22, MS_H, 1'b0, 32'h0, n);
        check("b2b_spacing2", 32'(last_done_cyc - d1), 32'(SPACING_LIT));
        check("b2b_hs_lit", last_rdata, 32'hFFFFBEEF);
        req(1'b1, 1'b0, 32'h20, MS_W, 1'b0, 32'h0, n);
        check("b2b_w_lit", last_rdata, 32'hBEEF5678);

        idle(LAT + 3);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        check("acc_q_drained", 32'(acc_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter AW, default 12, meaning SRAM word-address width (memory holds 2^AW 32-bit words).
REQ-002 Parameter WAIT, default 2, meaning wait-state count inserted before each SRAM access (range 0..15).
REQ-003 clk  input  1  clock; all logic is sampled on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_rden  input  1  read request from the core; level, held until done.
REQ-006 req_wren  input  1  write request from the core; level, held until done.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_size  input  2  access size as mem_size_t: MS_B, MS_H, MS_W.
REQ-009 req_unsigned  input  1  zero-extend load result when 1, sign-extend when 0.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  load result, extended, valid while done=1.
REQ-013 err  output  1  access fault, valid while done=1.
REQ-014 sram_en, sram_we  output  1 each  SRAM port enable and write enable.
REQ-015 sram_addr  output  AW  SRAM word address (req_addr[AW+1:2]).
REQ-016 sram_be  output  4  SRAM byte enables; sram_wdata  output  32  lane-aligned store data.
REQ-017 sram_rdata  input  32  SRAM read data, one cycle after sram_en with sram_we=0.

Function
REQ-018 FSM states: IDLE, WAITST, ACCESS, RESP (rsp_state_t).
REQ-019 In IDLE, if req_rden or req_wren is high, latch the full request; go to WAITST when the wait count is nonzero, else to ACCESS.
REQ-020 WAITST decrements a 4-bit counter loaded with WAIT; it goes to ACCESS when the counter reaches 1.
REQ-021 ACCESS drives sram_en=1 for exactly one cycle; sram_we=1 only for a legal write; then go to RESP.
REQ-022 RESP asserts done=1 for one cycle, then returns to IDLE; IDLE never samples in the same cycle as done.
REQ-023 Latency: a request seen in IDLE at cycle N gives done at cycle N+WAIT+2.
REQ-024 Load result: select the byte or half by addr[1:0] from sram_rdata, then extend per req_unsigned; a word is passed through unchanged.
REQ-025 Store lanes: MS_B gives be=0001<<addr[1:0] with the byte replicated on all lanes; MS_H gives be=0011<<addr[1:0] with the half replicated; MS_W gives be=1111.
REQ-026 Misaligned access (MS_H with addr[0]=1, or MS_W with addr[1:0]!=0) gives err=1 and rdata=0; no SRAM enable is issued, and the timing is unchanged.
REQ-027 Out-of-range access (any of addr[31:AW+2] nonzero) and simultaneous rden+wren are handled the same as misaligned, with err=1.
REQ-028 done, sram_en and sram_we are 0 in every cycle outside the states that REQ-021 and REQ-022 specify.

Reset
REQ-029 rst returns the block to IDLE and clears the wait counter; done=0, err=0, rdata=0, sram_en=0, sram_we=0.
REQ-030 rst asserted in WAITST or ACCESS aborts the request; no SRAM write is committed after the reset cycle, and no done pulse follows.

Configuration
REQ-031 Macro MEMRESP_WAIT_EN: when it is defined, WAITST and the counter follow REQ-020 with WAIT cycles.
REQ-032 When MEMRESP_WAIT_EN is undefined, WAIT is ignored, WAITST and the counter are not built, and latency is fixed at N+2.

Structure
REQ-033 A shared package holds mem_size_t, rsp_state_t, and the lane-extract and byte-enable functions.
REQ-034 Sub-module sram_1rw is a 2^AW x 32 synchronous-read, byte-enabled array, instantiated by the testbench and SoC top, not inside mem_responder.

Verification
REQ-035 With WAIT=2, write MS_W addr 0x10 data 0xDEADBEEF, then read MS_W addr 0x10: done 4 cycles after each request is sampled; rdata=0xDEADBEEF, err=0.
REQ-036 Write MS_B addr 0x13 data 0x80; read MS_B signed at 0x13 gives rdata=0xFFFFFF80; read MS_B unsigned gives 0x00000080; be during the write = 1000.
REQ-037 Read MS_H at 0x11 gives err=1, rdata=0, and sram_en never high; MS_W at 0x4000 with AW=12 gives err=1.
REQ-038 Write MS_W 0x20 with rst pulsed during WAITST: no done; a later read of 0x20 returns its prior value.
REQ-039 Issue back-to-back requests with rden held across done: the second request is accepted on the cycle after done, and done spacing is WAIT+3 cycles.
REQ-040 Build without MEMRESP_WAIT_EN: every request completes in 2 cycles regardless of WAIT=7.
